// File: rtl/rom_loader.sv
// rom_loader: filters the HPS ioctl ROM download by index, serializes each
// 16-bit word into two byte writes, routes every byte to one of four ROM
// regions (main CPU, sound CPU, tiles, sprites) and holds the core in reset
// until the image is written.
// Optional feature macro: ROM_CSUM_EN adds o_rom_csum, a 16-bit byte sum of
// every byte actually written.
module rom_loader #(
    parameter logic [7:0]  DL_INDEX = 8'd0,
    parameter int unsigned R1_BASE  = 'h0C000,
    parameter int unsigned R2_BASE  = 'h10000,
    parameter int unsigned R3_BASE  = 'h20000,
    parameter int unsigned ROM_END  = 'h30000,
    parameter int unsigned HOLD_CYC = 16
) (
    input  logic        i_clk_sys,
    input  logic        i_reset,
    input  logic        i_ioctl_download,
    input  logic [7:0]  i_ioctl_index,
    input  logic        i_ioctl_wr,
    input  logic [26:0] i_ioctl_addr,
    input  logic [15:0] i_ioctl_dout,
    output logic        o_ioctl_wait,
    output logic [3:0]  o_rom_we,
    output logic [16:0] o_rom_addr,
    output logic [7:0]  o_rom_data,
    output logic        o_core_reset,
    output logic        o_rom_ready,
    output logic        o_proto_err
`ifdef ROM_CSUM_EN
    ,
    output logic [15:0] o_rom_csum
`endif
);

    localparam int unsigned AW = 27;
    localparam int unsigned RW = 17;
    localparam int unsigned CW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LO    = 3'd1,
        S_HI    = 3'd2,
        S_DONE  = 3'd3,
        S_READY = 3'd4
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic            w_dl_match;
    logic            w_rise;
    logic            w_fall;
    logic            w_accept;
    logic            r_dl_match;
    logic            r_armed;
    logic            r_end_pend;
    logic [CW-1:0]   r_cnt;
    logic [AW-1:0]   r_word_addr;
    logic [7:0]      r_hi_byte;

    logic [AW-1:0]   w_byte_addr;
    logic            w_wait_nxt;
    logic [3:0]      w_we_nxt;
    logic [RW-1:0]   w_addr_nxt;
    logic [7:0]      w_data_nxt;

    logic            r_wait;
    logic [3:0]      r_we;
    logic [RW-1:0]   r_addr;
    logic [7:0]      r_data;
    logic            r_core_reset;
    logic            r_ready;
    logic            r_proto_err;

    // Address bit 0 is implied by the byte lane and never used.
    logic            w_unused_addr0;
    assign w_unused_addr0 = i_ioctl_addr[0];

    // One-hot region select for a byte address; zero past the end of ROM.
    function automatic logic [3:0] f_region_we(input logic [AW-1:0] a);
        if (a >= AW'(ROM_END))      f_region_we = 4'b0000;
        else if (a >= AW'(R3_BASE)) f_region_we = 4'b1000;
        else if (a >= AW'(R2_BASE)) f_region_we = 4'b0100;
        else if (a >= AW'(R1_BASE)) f_region_we = 4'b0010;
        else                        f_region_we = 4'b0001;
    endfunction

    // Byte offset inside the selected region.
    function automatic logic [RW-1:0] f_region_off(input logic [AW-1:0] a);
        if (a >= AW'(R3_BASE))      f_region_off = RW'(a - AW'(R3_BASE));
        else if (a >= AW'(R2_BASE)) f_region_off = RW'(a - AW'(R2_BASE));
        else if (a >= AW'(R1_BASE)) f_region_off = RW'(a - AW'(R1_BASE));
        else                        f_region_off = RW'(a);
    endfunction

    // Download qualification and edge detection; strobes need a seen start.
    assign w_dl_match = i_ioctl_download && (i_ioctl_index == DL_INDEX);
    assign w_rise     = w_dl_match && !r_dl_match;
    assign w_fall     = r_dl_match && !w_dl_match && r_armed;
    assign w_accept   = w_dl_match && i_ioctl_wr && (r_armed || w_rise);

    // State register.
    always_ff @(posedge i_clk_sys) begin
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    // Next state and next values of the registered byte-write outputs.
    always_comb begin
        w_state_nxt = r_state;
        w_byte_addr = '0;
        w_wait_nxt  = 1'b0;
        w_we_nxt    = 4'b0000;
        w_addr_nxt  = r_addr;
        w_data_nxt  = r_data;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_byte_addr = {i_ioctl_addr[26:1], 1'b0};
                    w_we_nxt    = f_region_we(w_byte_addr);
                    w_addr_nxt  = f_region_off(w_byte_addr);
                    w_data_nxt  = i_ioctl_dout[7:0];
                    w_wait_nxt  = 1'b1;
                    w_state_nxt = S_LO;
                end else if (w_fall) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_LO: begin
                // Latched address is even, so setting bit 0 never carries.
                w_byte_addr = r_word_addr | AW'(1);
                w_we_nxt    = f_region_we(w_byte_addr);
                w_addr_nxt  = f_region_off(w_byte_addr);
                w_data_nxt  = r_hi_byte;
                w_wait_nxt  = 1'b1;
                w_state_nxt = S_HI;
            end
            S_HI: begin
                w_state_nxt = (r_end_pend || w_fall) ? S_DONE : S_IDLE;
            end
            S_DONE: begin
                if (w_rise)                          w_state_nxt = S_IDLE;
                else if (r_cnt == CW'(HOLD_CYC - 1)) w_state_nxt = S_READY;
            end
            S_READY: begin
                if (w_rise) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Registered outputs.
    always_ff @(posedge i_clk_sys) begin
        if (i_reset) begin
            r_wait       <= 1'b0;
            r_we         <= 4'b0000;
            r_addr       <= '0;
            r_data       <= '0;
            r_core_reset <= 1'b1;
            r_ready      <= 1'b0;
            r_proto_err  <= 1'b0;
        end else begin
            r_wait       <= w_wait_nxt;
            r_we         <= w_we_nxt;
            r_addr       <= w_addr_nxt;
            r_data       <= w_data_nxt;
            r_core_reset <= (w_state_nxt != S_READY);
            r_ready      <= (w_state_nxt == S_READY);
            if (((r_state == S_LO) || (r_state == S_HI)) && w_accept)
                r_proto_err <= 1'b1;
        end
    end

    // Word latch, download tracking and hold counter.
    always_ff @(posedge i_clk_sys) begin
        if (i_reset) begin
            r_dl_match  <= 1'b0;
            r_armed     <= 1'b0;
            r_end_pend  <= 1'b0;
            r_cnt       <= '0;
            r_word_addr <= '0;
            r_hi_byte   <= '0;
        end else begin
            r_dl_match <= w_dl_match;
            if (w_rise)      r_armed <= 1'b1;
            else if (w_fall) r_armed <= 1'b0;
            if ((r_state == S_IDLE) && w_accept) begin
                r_word_addr <= {i_ioctl_addr[26:1], 1'b0};
                r_hi_byte   <= i_ioctl_dout[15:8];
            end
            if (r_state == S_HI)                r_end_pend <= 1'b0;
            else if ((r_state == S_LO) && w_fall) r_end_pend <= 1'b1;
            if (r_state == S_DONE) r_cnt <= r_cnt + CW'(1);
            else                   r_cnt <= '0;
        end
    end

`ifdef ROM_CSUM_EN
    logic [15:0] r_csum;

    // Running sum of written bytes; restarts with each download.
    always_ff @(posedge i_clk_sys) begin
        if (i_reset) r_csum <= '0;
        else         r_csum <= (w_rise ? 16'd0 : r_csum) +
                               ((|w_we_nxt) ? 16'(w_data_nxt) : 16'd0);
    end

    assign o_rom_csum = r_csum;
`endif

    assign o_ioctl_wait = r_wait;
    assign o_rom_we     = r_we;
    assign o_rom_addr   = r_addr;
    assign o_rom_data   = r_data;
    assign o_core_reset = r_core_reset;
    assign o_rom_ready  = r_ready;
    assign o_proto_err  = r_proto_err;

endmodule

// File: tb/tb_rom_loader.sv
// tb_rom_loader: table-driven word vectors with a byte-slot scoreboard, plus
// hand-written sequences for wrong index, download end, busy strobe and reset.
module tb_rom_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        download;
    logic [7:0]  index;
    logic        wr;
    logic [26:0] addr;
    logic [15:0] dout;
    logic        io_wait;
    logic [3:0]  rom_we;
    logic [16:0] rom_addr;
    logic [7:0]  rom_data;
    logic        core_reset;
    logic        rom_ready;
    logic        proto_err;
`ifdef ROM_CSUM_EN
    logic [15:0] rom_csum;
`endif

    rom_loader dut (
        .i_clk_sys        (clk),
        .i_reset          (reset),
        .i_ioctl_download (download),
        .i_ioctl_index    (index),
        .i_ioctl_wr       (wr),
        .i_ioctl_addr     (addr),
        .i_ioctl_dout     (dout),
        .o_ioctl_wait     (io_wait),
        .o_rom_we         (rom_we),
        .o_rom_addr       (rom_addr),
        .o_rom_data       (rom_data),
        .o_core_reset     (core_reset),
        .o_rom_ready      (rom_ready),
        .o_proto_err      (proto_err)
`ifdef ROM_CSUM_EN
        ,
        .o_rom_csum       (rom_csum)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  we;
        logic [16:0] addr;
        logic [7:0]  data;
    } slot_t;

    typedef struct {
        logic [26:0] addr;
        logic [15:0] dout;
        logic [3:0]  we_lo;
        logic [16:0] a_lo;
        logic [3:0]  we_hi;
        logic [16:0] a_hi;
    } vec_t;

    slot_t       q[$];
    vec_t        vecs[10];
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [15:0] exp_csum = 16'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_slot(input logic [3:0] w, input logic [16:0] a, input logic [7:0] d);
        slot_t s;
        s.we = w; s.addr = a; s.data = d;
        q.push_back(s);
        if (w != 4'b0000) exp_csum = exp_csum + 16'(d);
    endtask

    // Drive one strobe, queue both byte slots, and land on the t+3 cycle.
    task automatic send_word(input logic [26:0] a, input logic [15:0] d,
                             input logic [3:0] wl, input logic [16:0] al,
                             input logic [3:0] wh, input logic [16:0] ah);
        wr = 1'b1; addr = a; dout = d;
        push_slot(wl, al, d[7:0]);
        push_slot(wh, ah, d[15:8]);
        tick();
        wr = 1'b0;
        tick();
        tick();
        chk("wait_low_after_word", 32'(io_wait), 32'd0);
    endtask

    task automatic chk_reset_vals();
        chk("rst_wait",       32'(io_wait),    32'd0);
        chk("rst_we",         32'(rom_we),     32'd0);
        chk("rst_addr",       32'(rom_addr),   32'd0);
        chk("rst_data",       32'(rom_data),   32'd0);
        chk("rst_proto_err",  32'(proto_err),  32'd0);
        chk("rst_ready",      32'(rom_ready),  32'd0);
        chk("rst_core_reset", 32'(core_reset), 32'd1);
    endtask

    // Every cycle with ioctl_wait high is one byte slot; compare it to the queue.
    always @(negedge clk) begin
        if (io_wait === 1'b1) begin
            chk("slot_expected", 32'(q.size() != 0), 32'd1);
            if (q.size() != 0) begin
                slot_t e;
                e = q.pop_front();
                chk("slot_we", 32'(rom_we), 32'(e.we));
                if (e.we != 4'b0000) begin
                    chk("slot_addr", 32'(rom_addr), 32'(e.addr));
                    chk("slot_data", 32'(rom_data), 32'(e.data));
                end
            end
        end else if (io_wait === 1'b0 && rom_we !== 4'b0000) begin
            chk("we_outside_slot", 32'(rom_we), 32'd0);
        end
    end

    initial begin
        vecs[0] = '{27'h0000000, 16'hBEEF, 4'b0001, 17'h00000, 4'b0001, 17'h00001};
        vecs[1] = '{27'h000BFFE, 16'h1234, 4'b0001, 17'h0BFFE, 4'b0001, 17'h0BFFF};
        vecs[2] = '{27'h000C000, 16'h1234, 4'b0010, 17'h00000, 4'b0010, 17'h00001};
        vecs[3] = '{27'h000FFFF, 16'hABCD, 4'b0010, 17'h03FFE, 4'b0010, 17'h03FFF};
        vecs[4] = '{27'h0010000, 16'h1122, 4'b0100, 17'h00000, 4'b0100, 17'h00001};
        vecs[5] = '{27'h001FFFE, 16'h3344, 4'b0100, 17'h0FFFE, 4'b0100, 17'h0FFFF};
        vecs[6] = '{27'h0020000, 16'h5566, 4'b1000, 17'h00000, 4'b1000, 17'h00001};
        vecs[7] = '{27'h002FFFE, 16'h7788, 4'b1000, 17'h0FFFE, 4'b1000, 17'h0FFFF};
        vecs[8] = '{27'h0030000, 16'h99AA, 4'b0000, 17'h00000, 4'b0000, 17'h00000};
        vecs[9] = '{27'h7FFFFFE, 16'h0102, 4'b0000, 17'h00000, 4'b0000, 17'h00000};

        reset = 1'b1; download = 1'b0; index = 8'd0; wr = 1'b0; addr = '0; dout = '0;
        tick();
        tick();
        chk_reset_vals();
        reset = 1'b0;
        tick();

        // Wrong index: strobes must be ignored and the end edge must not count.
        download = 1'b1; index = 8'd254; wr = 1'b1; addr = 27'h0; dout = 16'h1111;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("wrongidx_wait", 32'(io_wait), 32'd0);
            chk("wrongidx_we",   32'(rom_we),  32'd0);
        end
        wr = 1'b0; download = 1'b0;
        repeat (20) tick();
        chk("wrongidx_core_reset", 32'(core_reset), 32'd1);
        chk("wrongidx_ready",      32'(rom_ready),  32'd0);
        index = 8'd0;

        // Main download through every region and past the end.
        download = 1'b1;
        exp_csum = 16'd0;
        tick();
        for (int i = 0; i < 10; i++)
            send_word(vecs[i].addr, vecs[i].dout, vecs[i].we_lo, vecs[i].a_lo,
                      vecs[i].we_hi, vecs[i].a_hi);
        download = 1'b0;
        tick();
        chk("done_core_reset", 32'(core_reset), 32'd1);
        chk("done_ready",      32'(rom_ready),  32'd0);
        repeat (15) tick();
        chk("hold_last_ready", 32'(rom_ready),  32'd0);
        tick();
        chk("ready_set",       32'(rom_ready),  32'd1);
        chk("ready_core_rst",  32'(core_reset), 32'd0);
`ifdef ROM_CSUM_EN
        chk("csum_main", 32'(rom_csum), 32'(exp_csum));
`endif

        // Restart from READY; busy strobe in LO; download ends in HI.
        download = 1'b1;
        tick();
        chk("restart_core_reset", 32'(core_reset), 32'd1);
        chk("restart_ready",      32'(rom_ready),  32'd0);
        wr = 1'b1; addr = 27'h100; dout = 16'hC3D4;
        push_slot(4'b0001, 17'h100, 8'hD4);
        push_slot(4'b0001, 17'h101, 8'hC3);
        tick();
        wr = 1'b1; addr = 27'h200; dout = 16'hFFFF;
        tick();
        wr = 1'b0; download = 1'b0;
        chk("busy_proto_err", 32'(proto_err), 32'd1);
        tick();
        chk("endhi_wait",       32'(io_wait),    32'd0);
        chk("endhi_core_reset", 32'(core_reset), 32'd1);
        repeat (15) tick();
        chk("endhi_ready_early", 32'(rom_ready), 32'd0);
        tick();
        chk("endhi_ready",      32'(rom_ready),  32'd1);
        chk("endhi_core_rst0",  32'(core_reset), 32'd0);
        chk("proto_err_sticky", 32'(proto_err),  32'd1);

        // Reset during LO abandons the word; a fresh 4-word download completes.
        download = 1'b1;
        tick();
        wr = 1'b1; addr = 27'h200; dout = 16'hAAAA;
        push_slot(4'b0001, 17'h200, 8'hAA);
        push_slot(4'b0001, 17'h201, 8'hAA);
        tick();
        wr = 1'b0; reset = 1'b1;
        tick();
        q.delete();
        chk_reset_vals();
        reset = 1'b0; download = 1'b0;
        tick();
        chk("post_rst_wait", 32'(io_wait), 32'd0);
        download = 1'b1;
        exp_csum = 16'd0;
        tick();
        send_word(27'h0000004, 16'h0102, 4'b0001, 17'h00004, 4'b0001, 17'h00005);
        send_word(27'h000C004, 16'h0304, 4'b0010, 17'h00004, 4'b0010, 17'h00005);
        send_word(27'h0010004, 16'h0506, 4'b0100, 17'h00004, 4'b0100, 17'h00005);
        send_word(27'h0020004, 16'h0708, 4'b1000, 17'h00004, 4'b1000, 17'h00005);
        download = 1'b0;
        tick();
        repeat (15) tick();
        chk("rerun_ready_early", 32'(rom_ready), 32'd0);
        tick();
        chk("rerun_ready",      32'(rom_ready),  32'd1);
        chk("rerun_core_reset", 32'(core_reset), 32'd0);
`ifdef ROM_CSUM_EN
        chk("csum_rerun", 32'(rom_csum), 32'h24);
`endif

        tick();
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
